// File: rtl/vdac_mux.sv
// vdac_mux: selects one of NSRC synchronous video sources, converts its colour
// to OUT_W bits per channel and drives the VDAC with a fixed 2-cycle latency.
// Source switches are armed by sel_stb and happen on the next rising vs of the
// current source, or after TIMEOUT cycles in ARMED (TIMEOUT = 0 disables this).
// Optional feature macro: VDAC_MUX_GAMMA_RAM_EN (per-channel gamma RAM, mode 10).
//
// Ports:
//   clk, rst                      video clock, asynchronous active-high reset
//   src_r/g/b [NSRC*IN_W]         packed per-source colour, source k at [k*IN_W +: IN_W]
//   src_hs/vs/de [NSRC]           per-source syncs and data enable
//   src_mode [NSRC*2]             per-source mode: 00 scale, 01 shift, 10 gamma, 11 scale
//   sel_req, sel_stb              source request and strobe
//   lut_we/ch/addr/wdata          gamma RAM write port (ch 0=R 1=G 2=B 3=none)
//   v_r/g/b [OUT_W], v_hs/vs/de   converted colour and delayed syncs
//   cur_sel, busy                 active source, high while a switch is armed
//   sel_done/timeout/err          single-cycle status pulses
module vdac_mux #(
  parameter int unsigned NSRC    = 2,
  parameter int unsigned IN_W    = 5,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned MAXCODE = 24,
  parameter int unsigned TIMEOUT = 1048575,
  parameter int unsigned DEF_SEL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC*IN_W-1:0]      src_r,
  input  logic [NSRC*IN_W-1:0]      src_g,
  input  logic [NSRC*IN_W-1:0]      src_b,
  input  logic [NSRC-1:0]           src_hs,
  input  logic [NSRC-1:0]           src_vs,
  input  logic [NSRC-1:0]           src_de,
  input  logic [NSRC*2-1:0]         src_mode,
  input  logic [$clog2(NSRC)-1:0]   sel_req,
  input  logic                      sel_stb,
  input  logic                      lut_we,
  input  logic [1:0]                lut_ch,
  input  logic [IN_W-1:0]           lut_addr,
  input  logic [OUT_W-1:0]          lut_wdata,
  output logic [OUT_W-1:0]          v_r,
  output logic [OUT_W-1:0]          v_g,
  output logic [OUT_W-1:0]          v_b,
  output logic                      v_hs,
  output logic                      v_vs,
  output logic                      v_de,
  output logic [$clog2(NSRC)-1:0]   cur_sel,
  output logic                      busy,
  output logic                      sel_done,
  output logic                      sel_timeout,
  output logic                      sel_err
);

  localparam int unsigned SEL_W   = $clog2(NSRC);
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int unsigned PROD_W  = IN_W + OUT_W;
  localparam int unsigned FULL    = (1 << OUT_W) - 1;

  typedef enum logic {RUN, ARMED} state_t;

  // Scale mode: floor(x*FULL/MAXCODE), saturating at full scale.
  function automatic logic [OUT_W-1:0] scale_code(input logic [IN_W-1:0] x);
    logic [PROD_W-1:0] q;
    if (32'(x) >= MAXCODE) return OUT_W'(FULL);
    q = (PROD_W'(x) * PROD_W'(FULL)) / PROD_W'(MAXCODE);
    return OUT_W'(q);
  endfunction

  function automatic logic [OUT_W-1:0] convert(input logic [IN_W-1:0]  x,
                                               input logic [1:0]       mode,
                                               input logic [OUT_W-1:0] gamma);
    case (mode)
      2'b01:   return OUT_W'(x) << (OUT_W - IN_W);
      2'b10:   return gamma;
      default: return scale_code(x);
    endcase
  endfunction

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  pending, pending_nxt, cur_sel_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              vs_hist, vs_hist_nxt;
  logic              done_nxt, to_nxt, err_nxt;

  logic [IN_W-1:0]   sel_r, sel_g, sel_b;
  logic              sel_hs, sel_vs, sel_de, pend_vs;
  logic [1:0]        sel_mode;

  logic [IN_W-1:0]   s1_r, s1_g, s1_b;
  logic              s1_hs, s1_vs, s1_de;
  logic [1:0]        s1_mode;
  logic [OUT_W-1:0]  gam_r, gam_g, gam_b;

  logic              req_bad, vs_rise, to_hit;

  // Source mux for the active source, plus the pending source's vs.
  always_comb begin
    sel_r    = '0;
    sel_g    = '0;
    sel_b    = '0;
    sel_hs   = 1'b0;
    sel_vs   = 1'b0;
    sel_de   = 1'b0;
    sel_mode = '0;
    pend_vs  = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (cur_sel == SEL_W'(k)) begin
        sel_r    = src_r[k*IN_W +: IN_W];
        sel_g    = src_g[k*IN_W +: IN_W];
        sel_b    = src_b[k*IN_W +: IN_W];
        sel_hs   = src_hs[k];
        sel_vs   = src_vs[k];
        sel_de   = src_de[k];
        sel_mode = src_mode[k*2 +: 2];
      end
      if (pending == SEL_W'(k)) pend_vs = src_vs[k];
    end
  end

  assign req_bad = (32'(sel_req) >= NSRC);
  assign vs_rise = sel_vs & ~vs_hist;
  assign to_hit  = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));

  // Switch control next-state logic; a strobe always wins over edge/timeout.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    cur_sel_nxt = cur_sel;
    vs_hist_nxt = sel_vs;
    done_nxt    = 1'b0;
    to_nxt      = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      RUN: begin
        if (sel_stb) begin
          if (req_bad) begin
            err_nxt = 1'b1;
          end else if (sel_req != cur_sel) begin
            pending_nxt = sel_req;
            cnt_nxt     = '0;
            state_nxt   = ARMED;
          end
        end
      end
      ARMED: begin
        if (sel_stb) begin
          if (req_bad) begin
            err_nxt = 1'b1;
          end else if (sel_req == cur_sel) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            pending_nxt = sel_req;
            cnt_nxt     = '0;
          end
        end else if (vs_rise || to_hit) begin
          cur_sel_nxt = pending;
          vs_hist_nxt = pend_vs;   // new source's level, so no false edge
          done_nxt    = 1'b1;
          to_nxt      = ~vs_rise;
          cnt_nxt     = '0;
          state_nxt   = RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Switch control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pending     <= '0;
      cnt         <= '0;
      cur_sel     <= SEL_W'(DEF_SEL);
      vs_hist     <= 1'b0;
      busy        <= 1'b0;
      sel_done    <= 1'b0;
      sel_timeout <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      cnt         <= cnt_nxt;
      cur_sel     <= cur_sel_nxt;
      vs_hist     <= vs_hist_nxt;
      busy        <= (state_nxt == ARMED);
      sel_done    <= done_nxt;
      sel_timeout <= to_nxt;
      sel_err     <= err_nxt;
    end
  end

`ifdef VDAC_MUX_GAMMA_RAM_EN
  logic [OUT_W-1:0] ram_r [2**IN_W];
  logic [OUT_W-1:0] ram_g [2**IN_W];
  logic [OUT_W-1:0] ram_b [2**IN_W];

  // Gamma RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      case (lut_ch)
        2'd0:    ram_r[lut_addr] <= lut_wdata;
        2'd1:    ram_g[lut_addr] <= lut_wdata;
        2'd2:    ram_b[lut_addr] <= lut_wdata;
        default: ;
      endcase
    end
  end

  assign gam_r = ram_r[s1_r];
  assign gam_g = ram_g[s1_g];
  assign gam_b = ram_b[s1_b];
`else
  logic lut_unused;
  assign lut_unused = ^{lut_we, lut_ch, lut_addr, lut_wdata};

  // Without the RAM, mode 10 falls back to scaling.
  assign gam_r = scale_code(s1_r);
  assign gam_g = scale_code(s1_g);
  assign gam_b = scale_code(s1_b);
`endif

  // Two-stage datapath: capture the active source, then convert and blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r    <= '0;
      s1_g    <= '0;
      s1_b    <= '0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_mode <= '0;
      v_r     <= '0;
      v_g     <= '0;
      v_b     <= '0;
      v_hs    <= 1'b0;
      v_vs    <= 1'b0;
      v_de    <= 1'b0;
    end else begin
      s1_r    <= sel_r;
      s1_g    <= sel_g;
      s1_b    <= sel_b;
      s1_hs   <= sel_hs;
      s1_vs   <= sel_vs;
      s1_de   <= sel_de;
      s1_mode <= sel_mode;
      v_r     <= s1_de ? convert(s1_r, s1_mode, gam_r) : '0;
      v_g     <= s1_de ? convert(s1_g, s1_mode, gam_g) : '0;
      v_b     <= s1_de ? convert(s1_b, s1_mode, gam_b) : '0;
      v_hs    <= s1_hs;
      v_vs    <= s1_vs;
      v_de    <= s1_de;
    end
  end

endmodule

// File: tb/tb_vdac_mux.sv
// tb_vdac_mux: directed bench for vdac_mux with three sources and TIMEOUT=100.
module tb_vdac_mux;

  localparam int unsigned NSRC  = 3;
  localparam int unsigned IN_W  = 5;
  localparam int unsigned OUT_W = 8;

  logic                  clk;
  logic                  rst;
  logic [NSRC*IN_W-1:0]  src_r, src_g, src_b;
  logic [NSRC-1:0]       src_hs, src_vs, src_de;
  logic [NSRC*2-1:0]     src_mode;
  logic [1:0]            sel_req;
  logic                  sel_stb;
  logic                  lut_we;
  logic [1:0]            lut_ch;
  logic [IN_W-1:0]       lut_addr;
  logic [OUT_W-1:0]      lut_wdata;
  logic [OUT_W-1:0]      v_r, v_g, v_b;
  logic                  v_hs, v_vs, v_de;
  logic [1:0]            cur_sel;
  logic                  busy, sel_done, sel_timeout, sel_err;

  logic [IN_W-1:0]       col  [NSRC];
  logic [1:0]            mode [NSRC];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar k = 0; k < NSRC; k++) begin : g_pack
    assign src_r[k*IN_W +: IN_W] = col[k];
    assign src_g[k*IN_W +: IN_W] = col[k];
    assign src_b[k*IN_W +: IN_W] = col[k];
    assign src_mode[k*2 +: 2]    = mode[k];
  end

  vdac_mux #(
    .NSRC(NSRC), .IN_W(IN_W), .OUT_W(OUT_W), .MAXCODE(24),
    .TIMEOUT(100), .DEF_SEL(0)
  ) dut (
    .clk(clk), .rst(rst),
    .src_r(src_r), .src_g(src_g), .src_b(src_b),
    .src_hs(src_hs), .src_vs(src_vs), .src_de(src_de), .src_mode(src_mode),
    .sel_req(sel_req), .sel_stb(sel_stb),
    .lut_we(lut_we), .lut_ch(lut_ch), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .v_r(v_r), .v_g(v_g), .v_b(v_b), .v_hs(v_hs), .v_vs(v_vs), .v_de(v_de),
    .cur_sel(cur_sel), .busy(busy),
    .sel_done(sel_done), .sel_timeout(sel_timeout), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] req);
    sel_req = req;
    sel_stb = 1'b1;
    step();
    sel_stb = 1'b0;
  endtask

  logic [IN_W-1:0]  scale_in  [5];
  logic [OUT_W-1:0] scale_exp [5];
  logic [OUT_W-1:0] gamma_exp;

  initial begin
    scale_in  = '{5'd1, 5'd3, 5'd12, 5'd24, 5'd31};
    scale_exp = '{8'd10, 8'd31, 8'd127, 8'd255, 8'd255};
`ifdef VDAC_MUX_GAMMA_RAM_EN
    gamma_exp = 8'hA5;
`else
    gamma_exp = 8'd74;
`endif
    rst = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      col[k]  = '0;
      mode[k] = 2'b00;
    end
    src_hs = '0; src_vs = '0; src_de = '0;
    sel_req = '0; sel_stb = 1'b0;
    lut_we = 1'b0; lut_ch = '0; lut_addr = '0; lut_wdata = '0;

    // Reset state
    step(); step();
    check("rst_v_r", 32'(v_r), 0);
    check("rst_cur_sel", 32'(cur_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flags", 32'({sel_done, sel_timeout, sel_err}), 0);
    rst = 1'b0;

    // Scale mode, one new value per cycle, output exactly two cycles later
    src_de[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) col[0] = scale_in[i];
      step();
      if (i >= 1) begin
        check($sformatf("scale_r_%0d", i - 1), 32'(v_r), 32'(scale_exp[i - 1]));
        check($sformatf("scale_b_%0d", i - 1), 32'(v_b), 32'(scale_exp[i - 1]));
      end
    end

    // Shift mode, then blanking with syncs passing through
    mode[0] = 2'b01; col[0] = 5'd17; src_hs[0] = 1'b1; src_vs[0] = 1'b0;
    step(); step();
    check("shift_r", 32'(v_r), 136);
    check("shift_hs", 32'(v_hs), 1);
    check("shift_de", 32'(v_de), 1);
    src_de[0] = 1'b0; src_hs[0] = 1'b0; src_vs[0] = 1'b1;
    step();
    check("blank_lat_hs", 32'(v_hs), 1);
    step();
    check("blank_r", 32'(v_r), 0);
    check("blank_g", 32'(v_g), 0);
    check("blank_hs", 32'(v_hs), 0);
    check("blank_vs", 32'(v_vs), 1);
    check("blank_de", 32'(v_de), 0);
    src_vs[0] = 1'b0; src_de[0] = 1'b1; mode[0] = 2'b00; col[0] = 5'd1;
    col[1] = 5'd12; mode[1] = 2'b00; src_de[1] = 1'b1;
    step();

    // Switch on vs rising edge of the current source
    strobe(2'd1);
    check("arm_busy", 32'(busy), 1);
    check("arm_cur_sel", 32'(cur_sel), 0);
    step(); step();
    check("wait_busy", 32'(busy), 1);
    check("wait_done", 32'(sel_done), 0);
    src_vs[0] = 1'b1;
    step();
    check("vs_cur_sel", 32'(cur_sel), 1);
    check("vs_done", 32'(sel_done), 1);
    check("vs_timeout", 32'(sel_timeout), 0);
    check("vs_busy", 32'(busy), 0);
    step();
    check("vs_done_pulse", 32'(sel_done), 0);
    step();
    check("new_src_r", 32'(v_r), 127);

    // Forced switch after 100 cycles without a vs edge
    src_vs[2] = 1'b1;
    strobe(2'd2);
    check("to_busy", 32'(busy), 1);
    repeat (99) step();
    check("to_early_done", 32'(sel_done), 0);
    check("to_early_busy", 32'(busy), 1);
    step();
    check("to_done", 32'(sel_done), 1);
    check("to_timeout", 32'(sel_timeout), 1);
    check("to_cur_sel", 32'(cur_sel), 2);
    check("to_busy_low", 32'(busy), 0);

    // Out-of-range request
    strobe(2'd3);
    check("err_pulse", 32'(sel_err), 1);
    check("err_busy", 32'(busy), 0);
    check("err_cur_sel", 32'(cur_sel), 2);
    step();
    check("err_pulse_end", 32'(sel_err), 0);

    // Cancel by requesting the current source while armed
    strobe(2'd0);
    check("cancel_arm", 32'(busy), 1);
    strobe(2'd2);
    check("cancel_busy", 32'(busy), 0);
    check("cancel_done", 32'(sel_done), 0);
    check("cancel_cur_sel", 32'(cur_sel), 2);

    // Strobe beats a simultaneous vs edge
    strobe(2'd1);
    src_vs[2] = 1'b0;
    step();
    src_vs[2] = 1'b1;
    strobe(2'd0);
    check("prio_done", 32'(sel_done), 0);
    check("prio_busy", 32'(busy), 1);
    check("prio_cur_sel", 32'(cur_sel), 2);
    step();
    check("prio_no_late_edge", 32'(sel_done), 0);
    src_vs[2] = 1'b0;
    step();
    src_vs[2] = 1'b1;
    step();
    check("prio_switch_sel", 32'(cur_sel), 0);
    check("prio_switch_done", 32'(sel_done), 1);
    check("prio_switch_to", 32'(sel_timeout), 0);

    // Gamma mode on red
    lut_we = 1'b1; lut_ch = 2'd0; lut_addr = 5'd7; lut_wdata = 8'hA5;
    step();
    lut_we = 1'b0;
    mode[0] = 2'b10; col[0] = 5'd7; src_de[0] = 1'b1; src_vs[0] = 1'b0;
    step(); step();
    check("gamma_r", 32'(v_r), 32'(gamma_exp));

    // Reset while armed drops the pending request
    strobe(2'd1);
    check("rarm_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("rarm_rst_busy", 32'(busy), 0);
    check("rarm_rst_v_r", 32'(v_r), 0);
    step();
    rst = 1'b0;
    src_vs[0] = 1'b1;
    step();
    check("rarm_no_done", 32'(sel_done), 0);
    check("rarm_cur_sel", 32'(cur_sel), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
